// File: rtl/dcache_resp.sv
// dcache_resp: direct-mapped 4 KiB write-through, no-write-allocate data cache.
// Serves one load/store at a time; refills with a 16-beat burst, stores go to memory.
module dcache_resp (
    input  logic        clk,
    input  logic        rstn,
    input  logic        valid,
    input  logic [1:0]  op,
    input  logic [5:0]  index,
    input  logic [19:0] tag,
    input  logic [5:0]  offset,
    input  logic [3:0]  write_type,
    input  logic [31:0] w_data_CPU,
    output logic        addr_valid,
    output logic        data_valid,
    output logic [31:0] r_data_CPU,
    output logic        mem_rd_req,
    output logic [31:0] mem_rd_addr,
    input  logic        mem_rd_ready,
    input  logic        mem_rd_rvalid,
    input  logic [31:0] mem_rd_rdata,
    input  logic        mem_rd_rlast,
    output logic        mem_wr_req,
    output logic [31:0] mem_wr_addr,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_wr_strb,
    input  logic        mem_wr_ready
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        REFILL,
        RESP,
        WRITE_MEM,
        WR_DONE
    } state_t;

    state_t      state;

    logic [31:0] data_arr [0:1023];
    logic [19:0] tag_arr  [0:63];
    logic [63:0] vld;

    logic        wr_q;
    logic [5:0]  idx_q;
    logic [19:0] tag_q;
    logic [3:0]  word_q;
    logic [3:0]  wt_q;
    logic [31:0] wd_q;
    logic        hit_q;
    logic [3:0]  cnt;

    logic        hit_in;
    logic [31:0] rd_in;
    logic [3:0]  beat_word;
    logic        refill_we;
    logic        merge_we;
    logic [31:0] line_word;
    logic [31:0] merged;
    logic [31:0] crit_word;
    logic        unused_ok;

    assign unused_ok  = ^{op[1], offset[1:0]};

    // Requests are only taken in IDLE, and never while reset is held.
    assign addr_valid = rstn && (state == IDLE) && valid;

    // Tag check is done against the live request so the hit answer can be registered.
    assign hit_in     = vld[index] && (tag_arr[index] == tag);
    assign rd_in      = data_arr[{index, offset[5:2]}];

    // A stray early rlast is treated as the final beat.
    assign beat_word  = mem_rd_rlast ? 4'd15 : cnt;
    assign refill_we  = rstn && (state == REFILL) && mem_rd_rvalid;
    assign merge_we   = rstn && (state == LOOKUP) && wr_q && hit_q;
    assign line_word  = data_arr[{idx_q, word_q}];

    // The critical word may land on the same edge the response is registered.
    assign crit_word  = (word_q == beat_word) ? mem_rd_rdata : line_word;

    // Byte-lane merge of store data into the resident word.
    always_comb begin
        merged = line_word;
        for (int b = 0; b < 4; b++) begin
            if (wt_q[b]) begin
                merged[8*b +: 8] = wd_q[8*b +: 8];
            end
        end
    end

    // Data and tag arrays: refill beats and store-hit merges.
    always_ff @(posedge clk) begin
        if (refill_we) begin
            data_arr[{idx_q, beat_word}] <= mem_rd_rdata;
        end else if (merge_we) begin
            data_arr[{idx_q, word_q}] <= merged;
        end
        if (refill_we && mem_rd_rlast) begin
            tag_arr[idx_q] <= tag_q;
        end
    end

    // Control FSM with registered CPU and memory-side outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            vld         <= '0;
            data_valid  <= 1'b0;
            r_data_CPU  <= '0;
            mem_rd_req  <= 1'b0;
            mem_rd_addr <= '0;
            mem_wr_req  <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            mem_wr_strb <= '0;
            wr_q        <= 1'b0;
            idx_q       <= '0;
            tag_q       <= '0;
            word_q      <= '0;
            wt_q        <= '0;
            wd_q        <= '0;
            hit_q       <= 1'b0;
            cnt         <= '0;
        end else begin
            data_valid <= 1'b0;
            r_data_CPU <= '0;
            unique case (state)
                IDLE: begin
                    if (valid) begin
                        wr_q   <= op[0];
                        idx_q  <= index;
                        tag_q  <= tag;
                        word_q <= offset[5:2];
                        wt_q   <= write_type;
                        wd_q   <= w_data_CPU;
                        hit_q  <= hit_in;
                        state  <= LOOKUP;
                        if (!op[0] && hit_in) begin
                            data_valid <= 1'b1;
                            r_data_CPU <= rd_in;
                        end
                    end
                end
                LOOKUP: begin
                    if (wr_q) begin
                        mem_wr_req  <= 1'b1;
                        mem_wr_addr <= {tag_q, idx_q, word_q, 2'b00};
                        mem_wr_data <= wd_q;
                        mem_wr_strb <= wt_q;
                        state       <= WRITE_MEM;
                    end else if (hit_q) begin
                        state <= IDLE;
                    end else begin
                        vld[idx_q]  <= 1'b0;
                        mem_rd_req  <= 1'b1;
                        mem_rd_addr <= {tag_q, idx_q, 6'b0};
                        state       <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    if (mem_rd_ready) begin
                        mem_rd_req <= 1'b0;
                        cnt        <= '0;
                        state      <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_rd_rvalid) begin
                        cnt <= cnt + 4'd1;
                        if (mem_rd_rlast) begin
                            vld[idx_q] <= 1'b1;
                            data_valid <= 1'b1;
                            r_data_CPU <= crit_word;
                            state      <= RESP;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                WRITE_MEM: begin
                    if (mem_wr_ready) begin
                        mem_wr_req <= 1'b0;
                        data_valid <= 1'b1;
                        state      <= WR_DONE;
                    end
                end
                WR_DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_resp.sv
// tb_dcache_resp: directed and random accesses against a memory/cache reference
// model; the model tracks resident tags per set and a word-addressed backing store.
module tb_dcache_resp;

    logic        clk = 1'b0;
    logic        rstn;
    logic        valid;
    logic [1:0]  op;
    logic [5:0]  index;
    logic [19:0] tag;
    logic [5:0]  offset;
    logic [3:0]  write_type;
    logic [31:0] w_data_CPU;
    logic        addr_valid;
    logic        data_valid;
    logic [31:0] r_data_CPU;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_ready;
    logic        mem_rd_rvalid;
    logic [31:0] mem_rd_rdata;
    logic        mem_rd_rlast;
    logic        mem_wr_req;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_strb;
    logic        mem_wr_ready;

    always #5 clk = ~clk;

    dcache_resp dut (
        .clk(clk), .rstn(rstn), .valid(valid), .op(op), .index(index),
        .tag(tag), .offset(offset), .write_type(write_type),
        .w_data_CPU(w_data_CPU), .addr_valid(addr_valid),
        .data_valid(data_valid), .r_data_CPU(r_data_CPU),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
        .mem_rd_ready(mem_rd_ready), .mem_rd_rvalid(mem_rd_rvalid),
        .mem_rd_rdata(mem_rd_rdata), .mem_rd_rlast(mem_rd_rlast),
        .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_strb(mem_wr_strb),
        .mem_wr_ready(mem_wr_ready)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mem_q [logic [31:0]];
    logic        m_vld [64];
    logic [19:0] m_tag [64];

    task automatic check(input string name, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] memrd(input logic [31:0] a);
        if (mem_q.exists(a)) return mem_q[a];
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic memwr(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        logic [31:0] w;
        w = memrd(a);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        end
        mem_q[a] = w;
    endtask

    task automatic check_zero(input string name);
        check({name, "_addr_valid"}, addr_valid, 0);
        check({name, "_data_valid"}, data_valid, 0);
        check({name, "_rd_req"}, mem_rd_req, 0);
        check({name, "_wr_req"}, mem_wr_req, 0);
        check({name, "_r_data"}, r_data_CPU, 0);
        check({name, "_rd_addr"}, mem_rd_addr, 0);
        check({name, "_wr_addr"}, mem_wr_addr, 0);
        check({name, "_wr_data"}, mem_wr_data, 0);
        check({name, "_wr_strb"}, mem_wr_strb, 0);
    endtask

    task automatic mem_idle();
        mem_rd_ready  = 0;
        mem_rd_rvalid = 0;
        mem_rd_rlast  = 0;
        mem_wr_ready  = 0;
    endtask

    task automatic access(input bit wr, input logic [19:0] t,
                          input logic [5:0] ix, input logic [5:0] off,
                          input logic [3:0] wt, input logic [31:0] wd,
                          input int rdy_dly, input int gap_pct,
                          input int wr_dly, input int rst_beat,
                          input bit hold);
        logic [31:0] wa;
        logic [31:0] base;
        bit          exp_hit;
        bit          rd_seen;
        bit          wr_seen;
        bit          done;
        int          phase;
        int          dcnt;
        int          wcnt;
        int          b;
        int          last_n;
        int          rdy_n;
        wa      = {t, ix, off[5:2], 2'b00};
        base    = {t, ix, 6'b0};
        exp_hit = m_vld[ix] && (m_tag[ix] == t);
        rd_seen = 0;
        wr_seen = 0;
        done    = 0;
        phase   = 0;
        dcnt    = 0;
        wcnt    = 0;
        b       = 0;
        last_n  = -1;
        rdy_n   = -1;
        @(posedge clk); #1;
        valid      = 1;
        op         = {1'($urandom_range(1)), wr};
        index      = ix;
        tag        = t;
        offset     = off;
        write_type = wt;
        w_data_CPU = wd;
        @(negedge clk);
        check("accept_addr_valid", addr_valid, 1);
        check("accept_no_data_valid", data_valid, 0);
        for (int n = 1; n <= 400 && !done; n++) begin
            @(posedge clk); #1;
            if (hold) tag = t ^ 20'h5;
            else valid = 0;
            mem_idle();
            if (phase == 0 && mem_rd_req) begin
                rd_seen = 1;
                if (dcnt >= rdy_dly) begin
                    mem_rd_ready = 1;
                    phase = 1;
                end else begin
                    dcnt++;
                end
            end else if (phase == 1) begin
                if (b == rst_beat) begin
                    rstn  = 0;
                    valid = 0;
                    @(posedge clk); #1;
                    @(negedge clk);
                    check_zero("abort");
                    @(posedge clk); #1;
                    rstn          = 1;
                    mem_rd_rvalid = 1;
                    mem_rd_rdata  = 32'hFFFF_FFFF;
                    mem_rd_rlast  = 1;
                    @(posedge clk); #1;
                    mem_idle();
                    for (int i = 0; i < 64; i++) m_vld[i] = 0;
                    @(negedge clk);
                    check_zero("post_abort");
                    return;
                end else if ($urandom_range(99) >= gap_pct) begin
                    mem_rd_rvalid = 1;
                    mem_rd_rdata  = memrd(base + 32'(4 * b));
                    mem_rd_rlast  = (b == 15);
                    if (b == 15) begin
                        last_n = n;
                        phase  = 2;
                    end
                    b++;
                end
            end
            if (mem_wr_req && rdy_n < 0) begin
                wr_seen = 1;
                if (wcnt >= wr_dly) begin
                    mem_wr_ready = 1;
                    rdy_n = n;
                    memwr(wa, wd, wt);
                end else begin
                    wcnt++;
                end
            end
            @(negedge clk);
            check("busy_no_addr_valid", addr_valid, 0);
            if (mem_rd_req) check("rd_addr", mem_rd_addr, base);
            if (mem_wr_req) begin
                check("wr_addr", mem_wr_addr, wa);
                check("wr_data", mem_wr_data, wd);
                check("wr_strb", {28'b0, mem_wr_strb}, {28'b0, wt});
            end
            if (data_valid) begin
                done = 1;
                if (wr) begin
                    check("wr_rdata_zero", r_data_CPU, 0);
                    check("wr_latency", n, rdy_n + 1);
                    check("wr_issued", wr_seen, 1);
                    check("wr_no_refill", rd_seen, 0);
                end else begin
                    check("rd_data", r_data_CPU, memrd(wa));
                    check("rd_refill", rd_seen, !exp_hit);
                    if (exp_hit) check("hit_latency", n, 1);
                    else check("miss_latency", n, last_n + 1);
                    m_vld[ix] = 1;
                    m_tag[ix] = t;
                end
            end
        end
        check("done_in_budget", done, 1);
        valid = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] rt;
        rstn       = 0;
        valid      = 0;
        op         = 0;
        index      = 0;
        tag        = 0;
        offset     = 0;
        write_type = 0;
        w_data_CPU = 0;
        mem_rd_rdata = 0;
        mem_idle();
        for (int i = 0; i < 64; i++) begin
            m_vld[i] = 0;
            m_tag[i] = 0;
        end
        for (int i = 0; i < 16; i++) begin
            mem_q[32'h1234_50C0 + 32'(4 * i)] = 32'hA0 + 32'(i);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rstn = 1;
        @(negedge clk);

        access(0, 20'h12345, 6'd3, 6'h08, 4'h0, 0, 2, 0, 0, -1, 0);
        check("cold_read_value", r_data_CPU, 32'hA2);
        access(0, 20'h12345, 6'd3, 6'h08, 4'h0, 0, 0, 0, 0, -1, 0);
        check("warm_read_value", r_data_CPU, 32'hA2);
        access(1, 20'h12345, 6'd3, 6'h08, 4'b0011, 32'hDEAD_BEEF,
               0, 0, 3, -1, 0);
        access(0, 20'h12345, 6'd3, 6'h08, 4'h0, 0, 0, 0, 0, -1, 0);
        check("merged_read_value", r_data_CPU, 32'h0000_BEEF);
        access(1, 20'h00001, 6'd3, 6'h14, 4'hF, 32'h1357_9BDF,
               0, 0, 1, -1, 0);
        access(0, 20'h12345, 6'd3, 6'h08, 4'h0, 0, 0, 0, 0, -1, 0);
        access(1, 20'h12345, 6'd3, 6'h0C, 4'h0, 32'hCAFE_F00D,
               0, 0, 0, -1, 0);

        access(0, 20'h0ABCD, 6'd9, 6'h3C, 4'h0, 0, 5, 40, 0, -1, 1);
        for (int w = 0; w < 16; w++) begin
            access(0, 20'h0ABCD, 6'd9, 6'(4 * w), 4'h0, 0, 0, 0, 0, -1, 0);
        end

        access(0, 20'h00777, 6'd12, 6'h10, 4'h0, 0, 1, 20, 0, 7, 0);
        access(0, 20'h00777, 6'd12, 6'h10, 4'h0, 0, 1, 20, 0, -1, 0);
        access(0, 20'h12345, 6'd3, 6'h08, 4'h0, 0, 0, 0, 0, -1, 0);

        for (int k = 0; k < 150; k++) begin
            rt = 20'($urandom_range(3));
            access(1'($urandom_range(1)), rt, 6'($urandom_range(3)),
                   6'($urandom), 4'($urandom), $urandom,
                   $urandom_range(3), $urandom_range(50),
                   $urandom_range(3), -1, 1'($urandom_range(1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
